// File: rtl/tx_payload_fifo.sv
// Frame-committing byte FIFO for TX payloads: zero-latency FWFT read of committed bytes only.
// No backpressure: overflow or packet-limit frames are rolled back and flagged on drop_pulse.
module tx_payload_fifo #(
    parameter int DEPTH    = 2048,
    parameter int MAX_PKTS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    input  logic       wr_last,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    input  logic       pkt_txed,
    output logic [1:0] pkt_count,
    output logic       wr_full,
    output logic       rd_empty,
    output logic       drop_pulse,
    output logic       underflow
);

    localparam int              ADDR_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);
    localparam logic [1:0]      PKT_LIM  = 2'(MAX_PKTS);

    typedef enum logic [1:0] {WR_IDLE, WR_FRAME, WR_DROP} wr_state_t;

    wr_state_t       r_state;
    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_commit_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    logic [1:0]      r_pkt_count;
    logic            r_drop_pulse;
    logic            r_underflow;
    logic [7:0]      r_mem [DEPTH];

    logic            w_wr_full;
    logic            w_rd_empty;
    logic            w_in_frame;
    logic            w_store;
    logic            w_ovf;
    logic            w_pkt_lim;
    logic            w_commit;
    logic            w_dec;
    logic            w_rd;
    logic [ADDR_W:0] w_wr_ptr_nxt;

    assign w_wr_full    = (r_wr_ptr - r_rd_ptr) == FULL_LVL;
    assign w_rd_empty   = (r_rd_ptr == r_commit_ptr);
    assign w_in_frame   = (r_state != WR_DROP);
    // Full is taken from the registered pointers, so a same-cycle read never rescues a write.
    assign w_store      = wr_en && !w_wr_full && w_in_frame;
    assign w_ovf        = wr_en &&  w_wr_full && w_in_frame;
    assign w_pkt_lim    = w_store && wr_last && (r_pkt_count == PKT_LIM);
    assign w_commit     = w_store && wr_last && !w_pkt_lim;
    assign w_dec        = pkt_txed && (r_pkt_count != 2'd0);
    assign w_rd         = rd_en && !w_rd_empty;
    assign w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;

    assign rd_data    = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign wr_full    = w_wr_full;
    assign rd_empty   = w_rd_empty;
    assign pkt_count  = r_pkt_count;
    assign drop_pulse = r_drop_pulse;
    assign underflow  = r_underflow;

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= WR_IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_pkt_count  <= 2'd0;
            r_drop_pulse <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_drop_pulse <= w_ovf || w_pkt_lim;
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (rd_en && w_rd_empty) begin
                r_underflow <= 1'b1;
            end
            if (w_commit && !w_dec) begin
                r_pkt_count <= r_pkt_count + 2'd1;
            end else if (!w_commit && w_dec) begin
                r_pkt_count <= r_pkt_count - 2'd1;
            end

            case (r_state)
                WR_IDLE, WR_FRAME: begin
                    if (w_ovf) begin
                        r_wr_ptr <= r_commit_ptr;
                        r_state  <= wr_last ? WR_IDLE : WR_DROP;
                    end else if (w_pkt_lim) begin
                        r_wr_ptr <= r_commit_ptr;
                        r_state  <= WR_IDLE;
                    end else if (w_commit) begin
                        r_wr_ptr     <= w_wr_ptr_nxt;
                        r_commit_ptr <= w_wr_ptr_nxt;
                        r_state      <= WR_IDLE;
                    end else if (w_store) begin
                        r_wr_ptr <= w_wr_ptr_nxt;
                        r_state  <= WR_FRAME;
                    end
                end
                WR_DROP: begin
                    if (wr_en && wr_last) begin
                        r_state <= WR_IDLE;
                    end
                end
                default: r_state <= WR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_payload_fifo.sv
// Directed self-checking bench for tx_payload_fifo at DEPTH = 16.
module tb_tx_payload_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       wr_last;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       pkt_txed;
    logic [1:0] pkt_count;
    logic       wr_full;
    logic       rd_empty;
    logic       drop_pulse;
    logic       underflow;

    int errors = 0;
    int checks = 0;

    tx_payload_fifo #(.DEPTH(16), .MAX_PKTS(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .wr_last    (wr_last),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .pkt_txed   (pkt_txed),
        .pkt_count  (pkt_count),
        .wr_full    (wr_full),
        .rd_empty   (rd_empty),
        .drop_pulse (drop_pulse),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required < 500000", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        wr_data  = 8'h00;
        wr_en    = 1'b0;
        wr_last  = 1'b0;
        rd_en    = 1'b0;
        pkt_txed = 1'b0;
    endtask

    task automatic do_reset;
        idle_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic last);
        wr_data = d;
        wr_en   = 1'b1;
        wr_last = last;
        tick();
        wr_en   = 1'b0;
        wr_last = 1'b0;
    endtask

    function automatic logic [7:0] fb(input int k, input int b);
        case (b)
            0:       return 8'h00;
            1:       return 8'h03;
            2:       return 8'(k);
            3:       return 8'(k + 100);
            default: return 8'(255 - k);
        endcase
    endfunction

    task automatic test_reset;
        do_reset();
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL reset_rd_empty got=%b exp=1", rd_empty); end
        checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL reset_wr_full got=%b exp=0", wr_full); end
        checks++; if (pkt_count !== 2'd0) begin errors++; $display("FAIL reset_pkt_count got=%0d exp=0", pkt_count); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
        checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL reset_drop_pulse got=%b exp=0", drop_pulse); end
    endtask

    task automatic test_single_frame;
        logic [7:0] exp [5];
        exp = '{8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
        do_reset();
        for (int i = 0; i < 4; i++) wr_byte(exp[i], 1'b0);
        checks++; if (pkt_count !== 2'd0) begin errors++; $display("FAIL single_precommit_count got=%0d exp=0", pkt_count); end
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL single_precommit_empty got=%b exp=1", rd_empty); end
        wr_byte(exp[4], 1'b1);
        checks++; if (pkt_count !== 2'd1) begin errors++; $display("FAIL single_commit_count got=%0d exp=1", pkt_count); end
        checks++; if (rd_empty !== 1'b0) begin errors++; $display("FAIL single_commit_empty got=%b exp=0", rd_empty); end
        for (int i = 0; i < 5; i++) begin
            rd_en = 1'b1;
            checks++; if (rd_data !== exp[i]) begin errors++; $display("FAIL single_rd[%0d] got=%h exp=%h", i, rd_data, exp[i]); end
            tick();
        end
        rd_en = 1'b0;
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL single_drained_empty got=%b exp=1", rd_empty); end
        pkt_txed = 1'b1;
        tick();
        pkt_txed = 1'b0;
        checks++; if (pkt_count !== 2'd0) begin errors++; $display("FAIL single_txed_count got=%0d exp=0", pkt_count); end
    endtask

    task automatic test_uncommitted;
        logic [7:0] exp [4];
        exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        for (int i = 0; i < 3; i++) wr_byte(exp[i], 1'b0);
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL uncommit_empty got=%b exp=1", rd_empty); end
        checks++; if (pkt_count !== 2'd0) begin errors++; $display("FAIL uncommit_count got=%0d exp=0", pkt_count); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uncommit_underflow_pre got=%b exp=0", underflow); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uncommit_underflow got=%b exp=1", underflow); end
        wr_byte(exp[3], 1'b1);
        checks++; if (pkt_count !== 2'd1) begin errors++; $display("FAIL uncommit_late_commit got=%0d exp=1", pkt_count); end
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1;
            checks++; if (rd_data !== exp[i]) begin errors++; $display("FAIL uncommit_rd[%0d] got=%h exp=%h", i, rd_data, exp[i]); end
            tick();
        end
        rd_en = 1'b0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uncommit_sticky got=%b exp=1", underflow); end
    endtask

    task automatic test_overflow;
        do_reset();
        for (int i = 0; i < 10; i++) wr_byte(8'(8'h10 + i), i == 9);
        checks++; if (pkt_count !== 2'd1) begin errors++; $display("FAIL ovf_first_commit got=%0d exp=1", pkt_count); end
        for (int i = 0; i < 8; i++) begin
            wr_byte(8'(8'h80 + i), i == 7);
            if (i == 5) begin
                checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL ovf_full_before_drop got=%b exp=1", wr_full); end
            end
            if (i == 6) begin
                checks++; if (drop_pulse !== 1'b1) begin errors++; $display("FAIL ovf_drop_pulse got=%b exp=1", drop_pulse); end
                checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL ovf_rollback_full got=%b exp=0", wr_full); end
            end
            if (i == 7) begin
                checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL ovf_single_pulse got=%b exp=0", drop_pulse); end
            end
        end
        checks++; if (pkt_count !== 2'd1) begin errors++; $display("FAIL ovf_count got=%0d exp=1", pkt_count); end
        for (int i = 0; i < 10; i++) begin
            rd_en = 1'b1;
            checks++; if (rd_data !== 8'(8'h10 + i)) begin errors++; $display("FAIL ovf_rd[%0d] got=%h exp=%h", i, rd_data, 8'(8'h10 + i)); end
            tick();
        end
        rd_en = 1'b0;
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL ovf_drained got=%b exp=1", rd_empty); end
        // The next frame must land right after the first one if the rollback was exact.
        for (int i = 0; i < 3; i++) wr_byte(8'(8'hC0 + i), i == 2);
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1;
            checks++; if (rd_data !== 8'(8'hC0 + i)) begin errors++; $display("FAIL ovf_next_rd[%0d] got=%h exp=%h", i, rd_data, 8'(8'hC0 + i)); end
            tick();
        end
        rd_en = 1'b0;
    endtask

    task automatic test_pkt_limit;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            wr_byte(8'(8'h20 + 2 * f), 1'b0);
            wr_byte(8'(8'h21 + 2 * f), 1'b1);
        end
        checks++; if (pkt_count !== 2'd3) begin errors++; $display("FAIL lim_three got=%0d exp=3", pkt_count); end
        wr_byte(8'hE0, 1'b0);
        wr_byte(8'hE1, 1'b1);
        checks++; if (drop_pulse !== 1'b1) begin errors++; $display("FAIL lim_drop_pulse got=%b exp=1", drop_pulse); end
        checks++; if (pkt_count !== 2'd3) begin errors++; $display("FAIL lim_count_hold got=%0d exp=3", pkt_count); end
        for (int i = 0; i < 6; i++) begin
            rd_en = 1'b1;
            checks++; if (rd_data !== 8'(8'h20 + i)) begin errors++; $display("FAIL lim_rd[%0d] got=%h exp=%h", i, rd_data, 8'(8'h20 + i)); end
            tick();
        end
        rd_en = 1'b0;
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL lim_fourth_hidden got=%b exp=1", rd_empty); end
        pkt_txed = 1'b1;
        tick(); tick(); tick();
        checks++; if (pkt_count !== 2'd0) begin errors++; $display("FAIL lim_txed_to_zero got=%0d exp=0", pkt_count); end
        tick();
        pkt_txed = 1'b0;
        checks++; if (pkt_count !== 2'd0) begin errors++; $display("FAIL txed_at_zero got=%0d exp=0", pkt_count); end
        wr_byte(8'h51, 1'b1);
        wr_byte(8'h52, 1'b1);
        checks++; if (pkt_count !== 2'd2) begin errors++; $display("FAIL simul_setup got=%0d exp=2", pkt_count); end
        pkt_txed = 1'b1;
        wr_byte(8'h53, 1'b1);
        pkt_txed = 1'b0;
        checks++; if (pkt_count !== 2'd2) begin errors++; $display("FAIL simul_commit_txed got=%0d exp=2", pkt_count); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int b = 0; b < 5; b++) wr_byte(fb(0, b), b == 4);
        for (int k = 1; k < 40; k++) begin
            for (int b = 0; b < 5; b++) begin
                wr_data  = fb(k, b);
                wr_en    = 1'b1;
                wr_last  = (b == 4);
                rd_en    = 1'b1;
                pkt_txed = (b == 4);
                checks++; if (rd_data !== fb(k - 1, b)) begin errors++; $display("FAIL wrap_rd f%0d b%0d got=%h exp=%h", k - 1, b, rd_data, fb(k - 1, b)); end
                tick();
            end
            checks++; if (pkt_count !== 2'd1) begin errors++; $display("FAIL wrap_count f%0d got=%0d exp=1", k, pkt_count); end
        end
        idle_in();
        for (int b = 0; b < 5; b++) begin
            rd_en    = 1'b1;
            pkt_txed = (b == 4);
            checks++; if (rd_data !== fb(39, b)) begin errors++; $display("FAIL wrap_tail b%0d got=%h exp=%h", b, rd_data, fb(39, b)); end
            tick();
        end
        idle_in();
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL wrap_final_empty got=%b exp=1", rd_empty); end
        checks++; if (pkt_count !== 2'd0) begin errors++; $display("FAIL wrap_final_count got=%0d exp=0", pkt_count); end
    endtask

    task automatic test_async_reset;
        do_reset();
        wr_byte(8'h77, 1'b0);
        wr_byte(8'h78, 1'b1);
        wr_byte(8'h79, 1'b0);
        wr_byte(8'h7A, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (pkt_count !== 2'd0) begin errors++; $display("FAIL arst_count got=%0d exp=0", pkt_count); end
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL arst_empty got=%b exp=1", rd_empty); end
        checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL arst_full got=%b exp=0", wr_full); end
        checks++; if (dut.r_state !== 2'd0) begin errors++; $display("FAIL arst_state got=%0d exp=0", dut.r_state); end
        checks++; if (rd_data !== 8'h77) begin errors++; $display("FAIL arst_rd_data_mem0 got=%h exp=77", rd_data); end
        tick();
        rst = 1'b0;
        tick();
        wr_byte(8'h5A, 1'b1);
        checks++; if (pkt_count !== 2'd1) begin errors++; $display("FAIL arst_after_commit got=%0d exp=1", pkt_count); end
        checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL arst_after_rd got=%h exp=5a", rd_data); end
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        test_reset();
        test_single_frame();
        test_uncommitted();
        test_overflow();
        test_pkt_limit();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_payload_fifo.md
TX_PAYLOAD_FIFO -- requirements
Module: tx_payload_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 2048, meaning byte capacity of the storage (power of two).
REQ-002 SHALL have parameter MAX_PKTS, default 3, meaning the maximum number of committed frames held at once (fits the 2-bit count).
REQ-003 SHALL use one clock and an asynchronous, active-high reset:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have the following write-side ports:
- wr_data  in  8  frame byte from the host; the first 2 bytes of each frame are the length field (MSB first), the payload follows.
- wr_en  in  1  write strobe for wr_data.
- wr_last  in  1  qualifies wr_en; marks the final byte of the frame.
REQ-005 SHALL have the following read-side ports, which connect to the encapsulation stage:
- rd_en  in  1  read strobe from the encapsulator.
- rd_data  out  8  head byte of the storage, first-word-fall-through.
- pkt_txed  in  1  one-cycle pulse: one frame fully transmitted.
- pkt_count  out  2  number of committed, untransmitted frames.
REQ-006 SHALL have the following status ports:
- wr_full  out  1  no free byte location.
- rd_empty  out  1  no committed byte is available to read.
- drop_pulse  out  1  one-cycle pulse when a frame is discarded.
- underflow  out  1  sticky; set when rd_en is asserted while rd_empty.

Function
REQ-007 SHALL keep these pointers, each ADDR_W+1 bits wide with a wrap bit (ADDR_W = log2 DEPTH): wr_ptr, commit_ptr (the start of the current uncommitted frame) and rd_ptr.
REQ-008 SHALL drive wr_full = (wr_ptr - rd_ptr == DEPTH) and rd_empty = (rd_ptr == commit_ptr); the reader never sees uncommitted bytes.
REQ-009 SHALL drive rd_data combinationally from mem[rd_ptr] with zero latency; rd_en && !rd_empty advances rd_ptr on the next edge.
REQ-010 SHALL ignore rd_en while rd_empty (rd_ptr holds) and set underflow to 1.
REQ-011 SHALL implement a write FSM with three states: WR_IDLE, WR_FRAME and WR_DROP.
REQ-012 In WR_IDLE, wr_en SHALL store the byte, increment wr_ptr and go to WR_FRAME; if wr_last is also set, the frame SHALL be committed at once.
REQ-013 In WR_FRAME, wr_en && !wr_full SHALL store the byte; when wr_last is set, the frame SHALL commit (commit_ptr <= wr_ptr+1, pkt_count +1) and the FSM SHALL return to WR_IDLE.
REQ-014 Overflow: wr_en while wr_full in WR_IDLE or WR_FRAME SHALL discard the byte, roll wr_ptr back to commit_ptr, pulse drop_pulse and enter WR_DROP (or WR_IDLE if wr_last).
REQ-015 Packet limit: a frame whose wr_last arrives while pkt_count == MAX_PKTS SHALL be rolled back and dropped exactly as in REQ-014, and pkt_count SHALL stay at MAX_PKTS.
REQ-016 In WR_DROP, all write bytes SHALL be discarded; wr_last with wr_en SHALL return the FSM to WR_IDLE; no further drop_pulse is generated.
REQ-017 pkt_txed SHALL decrement pkt_count, and pkt_txed while pkt_count == 0 SHALL be ignored (no wrap).
REQ-018 A same-cycle commit and pkt_txed SHALL leave pkt_count unchanged.
REQ-019 Pointer arithmetic SHALL be modulo 2^(ADDR_W+1); the memory index SHALL be ptr[ADDR_W-1:0]; wrap-around SHALL be transparent to both sides.
REQ-020 Simultaneous read and write in one cycle SHALL both take effect; a write while wr_full and a read in the same cycle SHALL still count as overflow (full is evaluated before the read).

Reset
REQ-021 Asserting rst SHALL asynchronously clear wr_ptr, commit_ptr, rd_ptr, pkt_count, underflow and drop_pulse, force the FSM to WR_IDLE, and hold rd_empty = 1, wr_full = 0 and rd_data = mem[0].
REQ-022 Memory contents SHALL not be reset.
REQ-023 Reset mid-frame SHALL discard every stored and partial frame.

Verification
REQ-024 Single frame: write 00 03 AA BB CC with wr_last on CC -> pkt_count goes 0->1 on the edge after CC; rd_empty drops together; five rd_en cycles return 00,03,AA,BB,CC; then rd_empty = 1; pulsing pkt_txed gives pkt_count = 0.
REQ-025 Uncommitted isolation: write 3 bytes without wr_last -> rd_empty stays 1 and pkt_count = 0; rd_en sets underflow = 1 and rd_ptr is unchanged.
REQ-026 Overflow with DEPTH = 16: commit a 10-byte frame, then write 8 bytes of a new frame -> drop_pulse on byte 7; wr_ptr returns to 10; remaining bytes up to wr_last are ignored; pkt_count = 1; the first frame reads back intact.
REQ-027 Packet limit: commit 3 frames, write a 4th with wr_last -> drop_pulse; pkt_count stays 3; the 4th frame's bytes are never readable.
REQ-028 Simultaneous events: a commit and pkt_txed in the same cycle with pkt_count = 2 -> pkt_count stays 2; pkt_txed at pkt_count = 0 -> stays 0.
REQ-029 Wrap-around and reset: stream 40 frames of 5 bytes through DEPTH = 16 with the reader draining -> all bytes arrive in order; asserting rst mid-frame asynchronously -> pkt_count = 0, rd_empty = 1 and the FSM is in WR_IDLE before the next edge.
